// File: rtl/ctrl_mem_load_mb.sv
// Multi-bank memory loader: valid/ready stream -> one-hot bank writes + shared address.
// Define CTRL_MEM_LOAD_PINGPONG_EN for double-buffered (ping-pong) operation.
module ctrl_mem_load_mb #(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_SIZE   = 8,
    parameter int NUM_BANKS  = 4,
    localparam int ADDR_W    = $clog2(MEM_SIZE),
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  en_ext_ctrl,
    input  logic                  ext_load_addr,
    input  logic [ADDR_W-1:0]     ext_load_addr_val,
    input  logic [BANK_W-1:0]     ext_bank_val,
    input  logic                  ext_incr_addr,
    input  logic                  consume_done,
    output logic [NUM_BANKS-1:0]  mem_wr_en,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  wr_buf,
    output logic                  rd_buf,
    output logic                  load_done
);

    typedef enum logic {
        S_LOAD,
        S_FULL
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [1:0]        full_q, full_d;
    logic              wr_buf_q, wr_buf_d;
    logic              rd_buf_q, rd_buf_d;
    logic              load_done_q, load_done_d;
    logic              fire;
    logic              ext_ok;

    assign s_ready     = (state_q == S_LOAD);
    assign fire        = s_valid & s_ready;
    assign mem_wr_en   = fire ? (NUM_BANKS'(1) << bank_q) : '0;
    assign mem_addr    = addr_q;
    assign mem_wr_data = s_data;
    assign wr_buf      = wr_buf_q;
    assign rd_buf      = rd_buf_q;
    assign load_done   = load_done_q;

    assign ext_ok = (32'(ext_load_addr_val) < MEM_SIZE) &&
                    (32'(ext_bank_val) < NUM_BANKS);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        bank_d      = bank_q;
        full_d      = full_q;
        wr_buf_d    = wr_buf_q;
        rd_buf_d    = rd_buf_q;
        load_done_d = 1'b0;

        // Free before fill so a same-cycle consume avoids a ready bubble
        if (consume_done && full_d[rd_buf_q]) begin
            full_d[rd_buf_q] = 1'b0;
        end

        if (en_ext_ctrl) begin
            if (ext_load_addr) begin
                if (ext_ok) begin
                    addr_d = ext_load_addr_val;
                    bank_d = ext_bank_val;
                end
            end else if (ext_incr_addr) begin
                addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
            end
        end else if (fire) begin
            if (addr_q == LAST_ADDR) begin
                addr_d = '0;
                if (bank_q == LAST_BANK) begin
                    bank_d           = '0;
                    load_done_d      = 1'b1;
                    full_d[wr_buf_q] = 1'b1;
                end else begin
                    bank_d = bank_q + BANK_W'(1);
                end
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end

`ifdef CTRL_MEM_LOAD_PINGPONG_EN
        // rd tracks the oldest full buffer; wr moves to a free one
        if (!full_d[rd_buf_d] && full_d[~rd_buf_d]) begin
            rd_buf_d = ~rd_buf_d;
        end
        if (full_d[wr_buf_d] && !full_d[~wr_buf_d]) begin
            wr_buf_d = ~wr_buf_d;
        end
        state_d = (&full_d) ? S_FULL : S_LOAD;
`else
        state_d = (|full_d) ? S_FULL : S_LOAD;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LOAD;
            addr_q      <= '0;
            bank_q      <= '0;
            full_q      <= '0;
            wr_buf_q    <= 1'b0;
            rd_buf_q    <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            bank_q      <= bank_d;
            full_q      <= full_d;
            wr_buf_q    <= wr_buf_d;
            rd_buf_q    <= rd_buf_d;
            load_done_q <= load_done_d;
        end
    end

endmodule

// File: tb/tb_ctrl_mem_load_mb.sv
// Directed bench for ctrl_mem_load_mb (MEM_SIZE=4, NUM_BANKS=2), plus a
// MEM_SIZE=6/NUM_BANKS=3 instance for non-power-of-two range/wrap handling.
module tb_ctrl_mem_load_mb;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        en_ext_ctrl;
    logic        ext_load_addr;
    logic [1:0]  ext_load_addr_val;
    logic [0:0]  ext_bank_val;
    logic        ext_incr_addr;
    logic        consume_done;
    logic [1:0]  mem_wr_en;
    logic [1:0]  mem_addr;
    logic [15:0] mem_wr_data;
    logic        wr_buf;
    logic        rd_buf;
    logic        load_done;

    logic        r2, v2, en2, ld2, inc2, cd2;
    logic [2:0]  av2;
    logic [1:0]  bv2;
    logic [15:0] d2;
    logic        rdy2, wb2, rb2, done2;
    logic [2:0]  wen2;
    logic [2:0]  addr2;
    logic [15:0] wd2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_mem_load_mb #(
        .DATA_WIDTH(16), .MEM_SIZE(4), .NUM_BANKS(2)
    ) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .en_ext_ctrl(en_ext_ctrl), .ext_load_addr(ext_load_addr),
        .ext_load_addr_val(ext_load_addr_val), .ext_bank_val(ext_bank_val),
        .ext_incr_addr(ext_incr_addr), .consume_done(consume_done),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .wr_buf(wr_buf), .rd_buf(rd_buf), .load_done(load_done)
    );

    ctrl_mem_load_mb #(
        .DATA_WIDTH(16), .MEM_SIZE(6), .NUM_BANKS(3)
    ) dut2 (
        .clk(clk), .reset(r2),
        .s_valid(v2), .s_data(d2), .s_ready(rdy2),
        .en_ext_ctrl(en2), .ext_load_addr(ld2),
        .ext_load_addr_val(av2), .ext_bank_val(bv2),
        .ext_incr_addr(inc2), .consume_done(cd2),
        .mem_wr_en(wen2), .mem_addr(addr2), .mem_wr_data(wd2),
        .wr_buf(wb2), .rd_buf(rb2), .load_done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0] pat;
        int cnt;
        int ndone;
        reset = 1'b1; s_valid = 0; s_data = 16'h1234; en_ext_ctrl = 0;
        ext_load_addr = 0; ext_load_addr_val = 0; ext_bank_val = 0;
        ext_incr_addr = 0; consume_done = 0;
        r2 = 1; v2 = 0; en2 = 0; ld2 = 0; inc2 = 0; cd2 = 0;
        av2 = 0; bv2 = 0; d2 = 0;
        repeat (2) @(negedge clk);
        reset = 0; r2 = 0;
        #1;
        chk("rst_ready", 32'(s_ready), 1);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wen", 32'(mem_wr_en), 0);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_wbuf", 32'(wr_buf), 0);
        chk("rst_rbuf", 32'(rd_buf), 0);
        chk("wdata", 32'(mem_wr_data), 32'h1234);

`ifndef CTRL_MEM_LOAD_PINGPONG_EN
        // Full fill of both banks
        s_valid = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("fill_ready", 32'(s_ready), 1);
            chk("fill_wen", 32'(mem_wr_en), (i < 4) ? 1 : 2);
            chk("fill_addr", 32'(mem_addr), 32'(i % 4));
            chk("fill_done", 32'(load_done), 0);
            @(negedge clk);
        end
        #1;
        chk("full_done", 32'(load_done), 1);
        chk("full_ready", 32'(s_ready), 0);
        chk("full_wen", 32'(mem_wr_en), 0);
        @(negedge clk);
        #1;
        chk("full_done2", 32'(load_done), 0);
        chk("full_ready2", 32'(s_ready), 0);
        // Consume releases the buffer
        consume_done = 1;
        #1;
        chk("cons_ready0", 32'(s_ready), 0);
        @(negedge clk);
        consume_done = 0;
        #1;
        chk("cons_ready1", 32'(s_ready), 1);
        chk("cons_wen", 32'(mem_wr_en), 1);
        chk("cons_addr", 32'(mem_addr), 0);
        @(negedge clk);
        s_valid = 0;
        #1;
        chk("cons_addr1", 32'(mem_addr), 1);
        chk("cons_wen0", 32'(mem_wr_en), 0);
`endif

        // Gapped stream
        do_reset();
        pat = 6'b101101;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            s_valid = pat[i];
            #1;
            chk("gap_wen", 32'(mem_wr_en), pat[i] ? (1 << (cnt / 4)) : 0);
            chk("gap_addr", 32'(mem_addr), 32'(cnt % 4));
            @(negedge clk);
            if (pat[i]) cnt++;
        end
        s_valid = 1;
        #1;
        chk("gap_end_wen", 32'(mem_wr_en), 2);
        chk("gap_end_addr", 32'(mem_addr), 0);
        @(negedge clk);
        s_valid = 0;

        // External control
        do_reset();
        en_ext_ctrl = 1;
        ext_load_addr = 1; ext_load_addr_val = 2; ext_bank_val = 1;
        @(negedge clk);
        ext_load_addr = 0; s_valid = 1;
        #1;
        chk("ext_wen", 32'(mem_wr_en), 2);
        chk("ext_addr", 32'(mem_addr), 2);
        @(negedge clk);
        s_valid = 0;
        #1;
        chk("ext_hold", 32'(mem_addr), 2);
        ext_incr_addr = 1;
        @(negedge clk);
        #1;
        chk("ext_inc3", 32'(mem_addr), 3);
        @(negedge clk);
        ext_incr_addr = 0; s_valid = 1;
        #1;
        chk("ext_wrap_wen", 32'(mem_wr_en), 2);
        chk("ext_wrap_addr", 32'(mem_addr), 0);
        @(negedge clk);
        s_valid = 0;
        #1;
        chk("ext_nodone", 32'(load_done), 0);
        ext_load_addr = 1; ext_incr_addr = 1;
        ext_load_addr_val = 1; ext_bank_val = 0;
        @(negedge clk);
        ext_load_addr = 0; ext_incr_addr = 0;
        #1;
        chk("ext_prio", 32'(mem_addr), 1);
        ext_load_addr = 1; ext_load_addr_val = 0; ext_bank_val = 1;
        @(negedge clk);
        ext_load_addr = 0; en_ext_ctrl = 0; s_valid = 1;
        #1;
        chk("resume_wen", 32'(mem_wr_en), 2);
        chk("resume_addr", 32'(mem_addr), 0);
        @(negedge clk);
        s_valid = 0;
        #1;
        chk("resume_adv", 32'(mem_addr), 1);

        // Mid-burst reset
        do_reset();
        s_valid = 1;
        repeat (5) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1;
        chk("mrst_wen", 32'(mem_wr_en), 1);
        chk("mrst_addr", 32'(mem_addr), 0);
        chk("mrst_done", 32'(load_done), 0);
        chk("mrst_ready", 32'(s_ready), 1);
        @(negedge clk);
        s_valid = 0;

        // Range checks and wrap on non-power-of-two geometry
        en2 = 1; ld2 = 1; av2 = 4; bv2 = 2;
        @(negedge clk);
        ld2 = 0; v2 = 1;
        #1;
        chk("b_wen", 32'(wen2), 4);
        chk("b_addr", 32'(addr2), 4);
        v2 = 0; ld2 = 1; av2 = 6; bv2 = 0;
        @(negedge clk);
        ld2 = 0; v2 = 1;
        #1;
        chk("b_badaddr_wen", 32'(wen2), 4);
        chk("b_badaddr_addr", 32'(addr2), 4);
        v2 = 0; ld2 = 1; av2 = 1; bv2 = 3;
        @(negedge clk);
        ld2 = 0; v2 = 1;
        #1;
        chk("b_badbank_wen", 32'(wen2), 4);
        chk("b_badbank_addr", 32'(addr2), 4);
        v2 = 0; inc2 = 1;
        repeat (2) @(negedge clk);
        inc2 = 0; v2 = 1;
        #1;
        chk("b_wrap_addr", 32'(addr2), 0);
        chk("b_wrap_wen", 32'(wen2), 4);
        v2 = 0;

`ifdef CTRL_MEM_LOAD_PINGPONG_EN
        do_reset();
        ndone = 0;
        s_valid = 1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("pp_ready", 32'(s_ready), 1);
            chk("pp_wbuf", 32'(wr_buf), (i < 8) ? 0 : 1);
            chk("pp_wen", 32'(mem_wr_en), 1 << ((i % 8) / 4));
            chk("pp_addr", 32'(mem_addr), 32'(i % 4));
            chk("pp_done", 32'(load_done), (i == 8) ? 1 : 0);
            if (load_done) ndone++;
            @(negedge clk);
        end
        #1;
        if (load_done) ndone++;
        chk("pp_ndone", 32'(ndone), 2);
        chk("pp_block_ready", 32'(s_ready), 0);
        chk("pp_block_wen", 32'(mem_wr_en), 0);
        chk("pp_rbuf0", 32'(rd_buf), 0);
        consume_done = 1;
        @(negedge clk);
        consume_done = 0;
        #1;
        chk("pp_rbuf1", 32'(rd_buf), 1);
        chk("pp_ready1", 32'(s_ready), 1);
        chk("pp_wbuf0", 32'(wr_buf), 0);
        chk("pp_wen_after", 32'(mem_wr_en), 1);
        @(negedge clk);
        s_valid = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
